// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - instruction decode stage: 8-entry register file, field/control decode, load-use interlock, output register
// Optional DECODE_BYPASS_EN: a write-back in the accept cycle is forwarded to the register reads.
module decode_stage #(
    parameter int DATA_W = 16,
    parameter int PC_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       in_instr,
    input  logic [PC_W-1:0]   in_pc,
    input  logic              flush,
    input  logic              wb_en,
    input  logic [2:0]        wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        out_opcode,
    output logic [2:0]        out_rd,
    output logic [2:0]        out_rs,
    output logic [2:0]        out_rt,
    output logic [2:0]        out_shamt,
    output logic [DATA_W-1:0] out_imm,
    output logic [7:0]        out_addr,
    output logic [PC_W-1:0]   out_pc_1,
    output logic [DATA_W-1:0] out_rs_data,
    output logic [DATA_W-1:0] out_rt_data,
    output logic [DATA_W-1:0] out_rd_data,
    output logic              out_mem_read,
    output logic              out_mem_write,
    output logic              out_reg_write,
    output logic              out_branch,
    output logic              out_jump,
    output logic              out_hilo_write
);

    logic [DATA_W-1:0] r_regs [8];

    logic [3:0]        w_opcode;
    logic [2:0]        w_rd, w_rs, w_rt;
    logic [DATA_W-1:0] w_rs_data, w_rt_data, w_rd_data;
    logic              w_hazard, w_accept;
    logic              w_mem_read, w_mem_write, w_reg_write, w_branch, w_jump, w_hilo_write;

    assign w_opcode = in_instr[15:12];
    assign w_rd     = in_instr[11:9];
    assign w_rs     = in_instr[8:6];
    assign w_rt     = in_instr[5:3];

    // Load-use interlock: the loaded value is not yet available to the instruction behind it.
    assign w_hazard = out_valid && out_mem_read && (out_rd != 3'd0) &&
                      ((out_rd == w_rs) || (out_rd == w_rt));
    assign in_ready = !rst && !w_hazard && (!out_valid || out_ready);
    assign w_accept = in_valid && in_ready && !flush;

    always_comb begin
        w_rs_data = (w_rs == 3'd0) ? '0 : r_regs[w_rs];
        w_rt_data = (w_rt == 3'd0) ? '0 : r_regs[w_rt];
        w_rd_data = (w_rd == 3'd0) ? '0 : r_regs[w_rd];
`ifdef DECODE_BYPASS_EN
        if (wb_en && wb_addr != 3'd0) begin
            if (wb_addr == w_rs) w_rs_data = wb_data;
            if (wb_addr == w_rt) w_rt_data = wb_data;
            if (wb_addr == w_rd) w_rd_data = wb_data;
        end
`endif
    end

    always_comb begin
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        w_reg_write  = 1'b0;
        w_branch     = 1'b0;
        w_jump       = 1'b0;
        w_hilo_write = 1'b0;
        case (w_opcode)
            4'h8:    w_reg_write  = 1'b1;
            4'h9:    begin w_mem_read = 1'b1; w_reg_write = 1'b1; end
            4'hA:    w_mem_write  = 1'b1;
            4'hB:    w_branch     = 1'b1;
            4'hC:    w_jump       = 1'b1;
            4'hD:    ;
            4'hE:    w_hilo_write = 1'b1;
            4'hF:    w_reg_write  = 1'b1;
            default: w_reg_write  = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) r_regs[i] <= '0;
        end else if (wb_en && wb_addr != 3'd0) begin
            r_regs[wb_addr] <= wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid      <= 1'b0;
            out_opcode     <= '0;
            out_rd         <= '0;
            out_rs         <= '0;
            out_rt         <= '0;
            out_shamt      <= '0;
            out_imm        <= '0;
            out_addr       <= '0;
            out_pc_1       <= '0;
            out_rs_data    <= '0;
            out_rt_data    <= '0;
            out_rd_data    <= '0;
            out_mem_read   <= 1'b0;
            out_mem_write  <= 1'b0;
            out_reg_write  <= 1'b0;
            out_branch     <= 1'b0;
            out_jump       <= 1'b0;
            out_hilo_write <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (w_accept) begin
            out_valid      <= 1'b1;
            out_opcode     <= w_opcode;
            out_rd         <= w_rd;
            out_rs         <= w_rs;
            out_rt         <= w_rt;
            out_shamt      <= in_instr[2:0];
            out_imm        <= {{(DATA_W-6){in_instr[5]}}, in_instr[5:0]};
            out_addr       <= in_instr[7:0];
            out_pc_1       <= in_pc + PC_W'(1);
            out_rs_data    <= w_rs_data;
            out_rt_data    <= w_rt_data;
            out_rd_data    <= w_rd_data;
            out_mem_read   <= w_mem_read;
            out_mem_write  <= w_mem_write;
            out_reg_write  <= w_reg_write;
            out_branch     <= w_branch;
            out_jump       <= w_jump;
            out_hilo_write <= w_hilo_write;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - directed self-checking bench for decode_stage
module tb_decode_stage;

    localparam int DATA_W = 16;
    localparam int PC_W   = 8;

    logic              clk = 1'b0;
    logic              rst, in_valid, in_ready, flush, wb_en, out_valid, out_ready;
    logic [15:0]       in_instr;
    logic [PC_W-1:0]   in_pc;
    logic [2:0]        wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic [3:0]        out_opcode;
    logic [2:0]        out_rd, out_rs, out_rt, out_shamt;
    logic [DATA_W-1:0] out_imm, out_rs_data, out_rt_data, out_rd_data;
    logic [7:0]        out_addr;
    logic [PC_W-1:0]   out_pc_1;
    logic              out_mem_read, out_mem_write, out_reg_write, out_branch, out_jump, out_hilo_write;

    int errors = 0;
    int checks = 0;

    decode_stage #(.DATA_W(DATA_W), .PC_W(PC_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_opcode(out_opcode), .out_rd(out_rd), .out_rs(out_rs), .out_rt(out_rt),
        .out_shamt(out_shamt), .out_imm(out_imm), .out_addr(out_addr), .out_pc_1(out_pc_1),
        .out_rs_data(out_rs_data), .out_rt_data(out_rt_data), .out_rd_data(out_rd_data),
        .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
        .out_reg_write(out_reg_write), .out_branch(out_branch),
        .out_jump(out_jump), .out_hilo_write(out_hilo_write)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; wb_en = 1'b1; wb_addr = 3'd1; wb_data = 16'h1234;
        in_valid = 1'b1; in_instr = 16'h1000; in_pc = 8'h00;
        tick(); tick();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_opcode !== 4'h0 || out_pc_1 !== 8'h00 || out_reg_write !== 1'b0)
            begin errors++; $display("FAIL reset_outputs got=%h/%h/%b exp=0/00/0", out_opcode, out_pc_1, out_reg_write); end
        rst = 1'b0; wb_en = 1'b0; in_valid = 1'b0;
        tick();
        // R1 write during reset must have been dropped
        in_valid = 1'b1; in_instr = 16'h0040; in_pc = 8'h00;
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_rs_data !== 16'h0000)
            begin errors++; $display("FAIL reset_wb_ignored got=%b/%h exp=1/0000", out_valid, out_rs_data); end
        tick();
    endtask

    task automatic test_main();
        wb_en = 1'b1; wb_addr = 3'd1; wb_data = 16'h0003;
        tick();
        wb_en = 1'b0;
        in_valid = 1'b1; in_instr = 16'hEE49; in_pc = 8'h01;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL main_in_ready got=%b exp=1", in_ready); end
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_opcode !== 4'hE || out_rd !== 3'd7 || out_rs !== 3'd1 || out_rt !== 3'd1 || out_shamt !== 3'd1)
            begin errors++; $display("FAIL main_fields got=%b/%h/%0d/%0d/%0d/%0d exp=1/e/7/1/1/1", out_valid, out_opcode, out_rd, out_rs, out_rt, out_shamt); end
        checks++; if (out_rs_data !== 16'h0003 || out_rt_data !== 16'h0003 || out_rd_data !== 16'h0000)
            begin errors++; $display("FAIL main_data got=%h/%h/%h exp=0003/0003/0000", out_rs_data, out_rt_data, out_rd_data); end
        checks++; if (out_hilo_write !== 1'b1 || out_reg_write !== 1'b0 || out_mem_read !== 1'b0)
            begin errors++; $display("FAIL main_ctrl got=%b/%b/%b exp=1/0/0", out_hilo_write, out_reg_write, out_mem_read); end
        checks++; if (out_pc_1 !== 8'h02 || out_imm !== 16'h0009 || out_addr !== 8'h49)
            begin errors++; $display("FAIL main_pc_imm got=%h/%h/%h exp=02/0009/49", out_pc_1, out_imm, out_addr); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL main_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_hazard();
        in_valid = 1'b1; in_instr = 16'h9400; in_pc = 8'h10;
        tick();
        in_instr = 16'h0080; in_pc = 8'h11;
        #1;
        checks++; if (in_ready !== 1'b0 || out_mem_read !== 1'b1 || out_reg_write !== 1'b1 || out_rd !== 3'd2)
            begin errors++; $display("FAIL hazard_stall got=%b/%b/%b/%0d exp=0/1/1/2", in_ready, out_mem_read, out_reg_write, out_rd); end
        tick();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
            begin errors++; $display("FAIL hazard_bubble got=%b/%b exp=0/1", out_valid, in_ready); end
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_opcode !== 4'h0 || out_rs !== 3'd2 || out_pc_1 !== 8'h12)
            begin errors++; $display("FAIL hazard_retry got=%b/%h/%0d/%h exp=1/0/2/12", out_valid, out_opcode, out_rs, out_pc_1); end
        tick();
    endtask

    task automatic test_bypass();
        logic [15:0] exp_rs;
        wb_en = 1'b1; wb_addr = 3'd3; wb_data = 16'h1111;
        tick();
        wb_data = 16'hBEEF;
        in_valid = 1'b1; in_instr = 16'h00C0; in_pc = 8'h30;
`ifdef DECODE_BYPASS_EN
        exp_rs = 16'hBEEF;
`else
        exp_rs = 16'h1111;
`endif
        tick();
        wb_en = 1'b0;
        checks++; if (out_rs_data !== exp_rs) begin errors++; $display("FAIL bypass_same_cycle got=%h exp=%h", out_rs_data, exp_rs); end
        in_instr = 16'h00D8;
        tick();
        checks++; if (out_rs_data !== 16'hBEEF || out_rt_data !== 16'hBEEF)
            begin errors++; $display("FAIL bypass_next got=%h/%h exp=beef/beef", out_rs_data, out_rt_data); end
        wb_en = 1'b1; wb_addr = 3'd0; wb_data = 16'hFFFF;
        in_instr = 16'h0018;
        tick();
        wb_en = 1'b0; in_valid = 1'b0;
        checks++; if (out_rs_data !== 16'h0000 || out_rt_data !== 16'hBEEF)
            begin errors++; $display("FAIL bypass_r0 got=%h/%h exp=0000/beef", out_rs_data, out_rt_data); end
        tick();
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 16'h8A3F; in_pc = 8'h20;
        tick();
        in_instr = 16'hD000; in_pc = 8'h21;
        for (int i = 0; i < 3; i++) begin
            checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_opcode !== 4'h8 || out_rd !== 3'd5 ||
                          out_pc_1 !== 8'h21 || out_imm !== 16'hFFFF || out_rs_data !== 16'h0000 || out_reg_write !== 1'b1)
                begin errors++; $display("FAIL stall_hold%0d got=%b/%b/%h/%0d/%h/%h/%h/%b exp=0/1/8/5/21/ffff/0000/1",
                                         i, in_ready, out_valid, out_opcode, out_rd, out_pc_1, out_imm, out_rs_data, out_reg_write); end
            tick();
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_release got=%b exp=1", in_ready); end
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_opcode !== 4'hD || out_pc_1 !== 8'h22 ||
                      {out_mem_read, out_mem_write, out_reg_write, out_branch, out_jump, out_hilo_write} !== 6'b0)
            begin errors++; $display("FAIL stall_nop got=%b/%h/%h/%b%b%b%b%b%b exp=1/d/22/000000", out_valid, out_opcode, out_pc_1,
                                     out_mem_read, out_mem_write, out_reg_write, out_branch, out_jump, out_hilo_write); end
        tick();
    endtask

    task automatic test_boundary();
        in_valid = 1'b1; in_instr = 16'h0020; in_pc = 8'hFF;
        tick();
        checks++; if (out_pc_1 !== 8'h00 || out_imm !== 16'hFFE0 || out_addr !== 8'h20)
            begin errors++; $display("FAIL boundary_wrap got=%h/%h/%h exp=00/ffe0/20", out_pc_1, out_imm, out_addr); end
        flush = 1'b1; in_instr = 16'hC0AB; in_pc = 8'h05;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0 || out_pc_1 !== 8'h00 || out_jump !== 1'b0)
            begin errors++; $display("FAIL boundary_flush got=%b/%h/%b exp=0/00/0", out_valid, out_pc_1, out_jump); end
        tick();
    endtask

    task automatic test_reset_mid_hold();
        wb_en = 1'b1; wb_addr = 3'd4; wb_data = 16'h4444;
        tick();
        wb_en = 1'b0;
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 16'h9400; in_pc = 8'h40;
        tick();
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rsthold_in_ready got=%b exp=0", in_ready); end
        tick();
        rst = 1'b0; out_ready = 1'b1;
        checks++; if (out_valid !== 1'b0 || out_mem_read !== 1'b0 || out_rd !== 3'd0 || out_pc_1 !== 8'h00)
            begin errors++; $display("FAIL rsthold_clear got=%b/%b/%0d/%h exp=0/0/0/00", out_valid, out_mem_read, out_rd, out_pc_1); end
        in_valid = 1'b1; in_instr = 16'h0100; in_pc = 8'h41;
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_rs_data !== 16'h0000)
            begin errors++; $display("FAIL rsthold_regs got=%b/%h exp=1/0000", out_valid, out_rs_data); end
        tick();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0; flush = 1'b0;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0; out_ready = 1'b1;
        test_reset();
        test_main();
        test_hazard();
        test_bypass();
        test_stall();
        test_boundary();
        test_reset_mid_hold();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 16, register/data width (>=16).
REQ-002 SHALL have parameter PC_W, default 8, program counter width.
REQ-003 SHALL have ports:
- clk  input  1  single clock, all state on rising edge; synchronous active-high reset.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  fetch offers instruction.
- in_ready  output  1  stage accepts instruction this cycle.
- in_instr  input  16  instruction: [15:12] opcode, [11:9] rd, [8:6] rs, [5:3] rt, [2:0] shamt.
- in_pc  input  PC_W  PC of in_instr.
- flush  input  1  discard output-register contents.
- wb_en  input  1  register-file write enable.
- wb_addr  input  3  write index.
- wb_data  input  DATA_W  write data.
- out_valid  output  1  decoded bundle valid.
- out_ready  input  1  execute accepts bundle.
- out_opcode, out_rd, out_rs, out_rt, out_shamt  output  4/3/3/3/3  decoded fields.
- out_imm  output  DATA_W  in_instr[5:0] sign-extended.
- out_addr  output  8  in_instr[7:0] zero-extended jump/memory address.
- out_pc_1  output  PC_W  in_pc+1, modulo 2^PC_W.
- out_rs_data, out_rt_data, out_rd_data  output  DATA_W  register reads at rs, rt, rd.
- out_mem_read, out_mem_write, out_reg_write, out_branch, out_jump, out_hilo_write  output  1  control.

Function
REQ-004 SHALL hold 8 registers of DATA_W bits; R0 SHALL read as 0 and writes to R0 SHALL be ignored.
REQ-005 SHALL write wb_data to wb_addr at clock edge when wb_en=1, independent of handshake, stall, or flush.
REQ-006 SHALL capture decode into output registers when in_valid && in_ready: latency exactly 1 cycle.
REQ-007 SHALL drive in_ready = !rst && !hazard && (!out_valid || out_ready).
REQ-008 SHALL hold all out_* stable while out_valid=1 and out_ready=0.
REQ-009 SHALL clear out_valid at edge when out_ready=1 and no new instruction accepted.
REQ-010 Opcode map: 0x0-0x7 ALU (reg_write); 0x8 ADDI (reg_write); 0x9 LOAD (mem_read, reg_write); 0xA STORE (mem_write); 0xB BEQ (branch); 0xC JUMP (jump); 0xD NOP (no controls); 0xE MUL (hilo_write); 0xF MFHI/MFLO (reg_write, shamt[0] selects lo).
REQ-011 hazard SHALL be 1 when out_valid && out_mem_read && out_rd!=0 && (out_rd==in_instr rs || out_rd==in_instr rt).
REQ-012 During hazard with out_ready=1, stage SHALL emit a bubble (out_valid=0 next cycle); instruction retried next cycle.
REQ-013 flush=1 SHALL force out_valid=0 next edge and block acceptance that cycle (in_ready ignored); flush has priority over accept and hold.
REQ-014 out_pc_1 SHALL wrap: in_pc=2^PC_W-1 yields 0.
REQ-015 out_imm SHALL replicate bit 5 into bits DATA_W-1:6.

Reset
REQ-016 rst=1 SHALL clear all 8 registers, out_valid, all control outputs, and all data/field outputs to 0 at next edge.
REQ-017 rst mid-stall or mid-hold SHALL discard the pending bundle; in_ready=0 while rst=1.
REQ-018 wb_en during rst SHALL be ignored.

Configuration
REQ-019 Macro DECODE_BYPASS_EN defined: read of index equal to wb_addr with wb_en=1 in accept cycle SHALL return wb_data (write-before-read).
REQ-020 Macro undefined: same-cycle read SHALL return the pre-write value; new value visible from next accept.

Verification
REQ-021 Reset, then R1=0x0003 via wb; accept 0xEE49, pc=1 -> next cycle out_opcode=0xE, rd=7, rs=1, rt=1, shamt=1, out_rs_data=0x0003, out_hilo_write=1, out_pc_1=2.
REQ-022 Accept LOAD rd=2 (0x9400) then ADD rs=2 (0x0080) with out_ready=1 -> in_ready=0 one cycle, one bubble, ADD emitted cycle after.
REQ-023 out_ready=0 for 3 cycles with bundle valid -> outputs unchanged, in_ready=0; release -> next instruction accepted.
REQ-024 wb_en=1, wb_addr=3, wb_data=0xBEEF same cycle as accept reading rs=3 -> out_rs_data=0xBEEF with DECODE_BYPASS_EN, old value without.
REQ-025 pc=0xFF accept -> out_pc_1=0x00; constant 6'b100000 -> out_imm=0xFFE0; flush asserted with in_valid -> out_valid=0, nothing accepted.
